// File: rtl/hazard_controller.sv
// Hazard sequencer for the 5-stage RV32 core: decides advance/hold/flush for the PC and every
// pipeline register each cycle, and counts stall cycles and accepted redirects.
module hazard_controller #(
    parameter int REDIRECT_BUBBLES = 1,
    parameter int CNT_W            = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_hold,
    output logic             id_ex_flush,
    output logic             pipe_hold,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, REDIRECT} state_t;

    localparam logic [2:0] BUB_LOAD = 3'(REDIRECT_BUBBLES);

    state_t     state, state_nxt;
    logic [2:0] bub, bub_nxt;
    logic       mem_wait, load_use, flush_inc;

    // Once in MEM_WAIT the freeze lasts until the access completes, whatever mem_req does.
    assign mem_wait = (state == MEM_WAIT) ? !mem_ready : (mem_req && !mem_ready);
    assign load_use = ex_MemRead && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (ex_rd == id_rs1)) || (id_uses_rs2 && (ex_rd == id_rs2)));

    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_hold  = 1'b0;
        id_ex_flush = 1'b0;
        pipe_hold   = 1'b0;
        state_nxt   = state;
        bub_nxt     = bub;
        flush_inc   = 1'b0;
        if (mem_wait) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_hold  = 1'b1;
            pipe_hold   = 1'b1;
            state_nxt   = MEM_WAIT;
        end else if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_inc   = 1'b1;
            bub_nxt     = BUB_LOAD;
            state_nxt   = (BUB_LOAD != 3'd0) ? REDIRECT : RUN;
        end else if (bub != 3'd0) begin
            // Outside a freeze, a nonzero bub means a redirect shadow, including MEM_WAIT release.
            if_id_flush = 1'b1;
            bub_nxt     = bub - 3'd1;
            state_nxt   = (bub == 3'd1) ? RUN : REDIRECT;
        end else begin
            state_nxt = RUN;
            if (load_use) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= RUN;
            bub          <= 3'd0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            state <= state_nxt;
            bub   <= bub_nxt;
            if (!pc_write && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (flush_inc && (flush_events != '1))
                flush_events <= flush_events + CNT_W'(1);
        end
    end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard sequencer for the 5-stage RV32 core. It decides each cycle whether the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers advance, hold or are flushed. It covers load-use interlocks, EX-resolved branch/jump redirects with post-redirect fetch bubbles, and multi-cycle data-memory waits. It sits beside the datapath, drives the write-enable/flush pins of every pipeline register and the PC, and exports stall and flush performance counters.

## Interface
- REDIRECT_BUBBLES, 1, extra cycles IF/ID is flushed after a redirect to cover synchronous imem latency; legal range 0..7
- CNT_W, 32, width of each performance counter
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1 each  the ID instruction actually reads that source
- ex_MemRead  in  1  the instruction in EX is a load
- ex_rd  in  5  destination register of the instruction in EX
- ex_redirect  in  1  a branch is taken or a jump occurs in EX; the PC mux selects the target this cycle
- mem_req  in  1  the MEM stage issues a data-memory access this cycle
- mem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  the PC register loads its next value
- if_id_write  out  1  IF/ID loads
- if_id_flush  out  1  IF/ID loads a NOP
- id_ex_hold  out  1  ID/EX keeps its contents
- id_ex_flush  out  1  ID/EX loads its reset bubble
- pipe_hold  out  1  EX/MEM and MEM/WB keep their contents
- stall_cycles  out  CNT_W  count of cycles with pc_write=0
- flush_events  out  CNT_W  count of accepted redirects

## Operation
- FSM states: RUN, MEM_WAIT, REDIRECT. Internal bubble counter bub (3 bits).
- Control outputs are combinational from state, bub and inputs. Defaults: pc_write=1, if_id_write=1, all others 0.
- Events are evaluated in priority order: memory wait > redirect > load-use.
- Memory wait: mem_req=1 and mem_ready=0, in any state.
  - Outputs: pc_write=0, if_id_write=0, id_ex_hold=1, pipe_hold=1, both flushes 0.
  - Next state is MEM_WAIT. bub is held.
- MEM_WAIT:
  - While mem_ready=0, the freeze outputs above apply.
  - In the cycle mem_ready=1, the freeze is released. The cycle is decoded as in RUN/REDIRECT: REDIRECT if bub!=0, otherwise RUN, including redirect and load-use checks.
  - Next state follows from that decode.
- Redirect: ex_redirect=1 with no memory wait.
  - Outputs: if_id_flush=1, id_ex_flush=1, pc_write=1.
  - Actions: flush_events is incremented and bub is loaded with REDIRECT_BUBBLES.
  - Next state: REDIRECT if REDIRECT_BUBBLES>0, otherwise RUN.
- REDIRECT, with no new event: if_id_flush=1, pc_write=1. bub is decremented; the state moves to RUN when bub reaches 0 after the decrement.
- A new ex_redirect while in REDIRECT reloads bub. The new redirect takes priority.
- Load-use: applies in RUN, or on MEM_WAIT release, with no redirect.
  - Condition: ex_MemRead=1, ex_rd!=0, and either (id_uses_rs1 and ex_rd==id_rs1) or (id_uses_rs2 and ex_rd==id_rs2).
  - Outputs: pc_write=0, if_id_write=0, id_ex_flush=1. The state stays RUN.
  - The check is suppressed in REDIRECT, because ID holds a bubble there.
- Counters saturate at all-ones and never wrap. stall_cycles increments in every cycle where pc_write=0.

## Timing
- Reset (reset_n low, asynchronous): state=RUN, bub=0, stall_cycles=0, flush_events=0.
- During and after reset, control outputs are the RUN decode of the current inputs. With idle inputs: pc_write=1, if_id_write=1, all others 0.
- Control latency is zero cycles: a hazard input asserted in cycle N affects the outputs in cycle N.
- Redirect in cycle N: both flushes are asserted in N, and if_id_flush stays asserted for cycles N+1..N+REDIRECT_BUBBLES. RUN resumes in N+REDIRECT_BUBBLES+1, provided no memory wait intervenes.
- A memory wait inside REDIRECT freezes bub. The remaining bubbles resume after release, so bubbles are never lost or duplicated.
- A load-use stall lasts exactly 1 cycle, because the load then leaves EX.
- mem_ready=1 with mem_req=0 is ignored.
- reset_n asserted in MEM_WAIT or REDIRECT returns the block immediately to RUN with bub=0.

## Test plan
- Load-use: ex_MemRead=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> for 1 cycle pc_write=0, if_id_write=0, id_ex_flush=1; stall_cycles goes 0->1. The same case with ex_rd=0 -> no stall.
- Redirect with REDIRECT_BUBBLES=2: ex_redirect pulse in cycle 10 -> id_ex_flush=1 in cycle 10 only; if_id_flush=1 in cycles 10-12; flush_events=1; RUN from cycle 13.
- Memory wait: mem_req=1 with mem_ready=0 for 3 cycles, then 1 -> pc_write=0, id_ex_hold=1, pipe_hold=1 for 3 cycles; released in cycle 4; stall_cycles +=3.
- Simultaneous events: mem wait, ex_redirect and a load-use hazard all asserted together -> freeze only. In the release cycle the redirect is taken (both flushes, no load-use stall).
- Memory wait in REDIRECT with 1 bubble left: freeze for 2 cycles -> after release, if_id_flush=1 for exactly 1 more cycle, then RUN.
- Asynchronous reset asserted mid-MEM_WAIT (between clock edges) -> outputs return to idle defaults immediately; counters read 0. Saturation: preload a counter to all-ones -> it stays at all-ones.
